calc_op_sequencer: RTL and testbench

//  Sequences the 8-bit ripple-carry adder/subtractor of the two-function calculator.
//  - Collects operand A, operand B and the operation through strobes.
//  - Drives the combinational adder and waits one settle cycle.
//  - Captures the sum and the Cout/Neg/Ovr/Zero flags into result registers.
//  - Supports chained operations: the previous result becomes the next operand A.

---
 rtl/calc_op_sequencer.sv | 174 +++++++++++++++++
 tb/tb_calc_op_sequencer.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/calc_op_sequencer.sv
// calc_op_sequencer: operand/op sequencer for the 8-bit adder/subtractor.
// Optional build macro SATURATE_EN clamps overflowed results to max/min signed.
module calc_op_sequencer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] data_in,
    input  logic             load_a,
    input  logic             load_b,
    input  logic             op_sub,
    input  logic             go,
    input  logic             clear,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic             alu_sub,
    input  logic [WIDTH-1:0] alu_s,
    input  logic             alu_cout,
    input  logic             alu_neg,
    input  logic             alu_ovr,
    input  logic             alu_zero,
    output logic [WIDTH-1:0] result,
    output logic [3:0]       flags,
    output logic             busy,
    output logic             done,
    output logic             err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HAVE_A,
        S_HAVE_B,
        S_EXEC,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             sub_q, sub_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [3:0]       flg_q, flg_d;
    logic             settle_q, settle_d;
    logic             done_q, done_d;
    logic             err_q, err_d;

    logic [WIDTH-1:0] cap_res;
    logic [3:0]       cap_flg;

    // Result/flags as they would be captured from the adder this cycle
    always_comb begin
        cap_res = alu_s;
        cap_flg = {alu_cout, alu_neg, alu_ovr, alu_zero};
`ifdef SATURATE_EN
        if (alu_ovr) begin
            cap_res = a_q[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                   : {1'b0, {(WIDTH-1){1'b1}}};
            cap_flg = {alu_cout, cap_res[WIDTH-1], 1'b1, 1'b0};
        end
`endif
    end

    // Next-state and register-update logic; strobe priority clear>load_a>load_b>go
    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        sub_d    = sub_q;
        res_d    = res_q;
        flg_d    = flg_q;
        settle_d = 1'b0;
        done_d   = 1'b0;
        err_d    = 1'b0;
        if (clear) begin
            state_d = S_IDLE;
            a_d     = '0;
            b_d     = '0;
            sub_d   = 1'b0;
            res_d   = '0;
            flg_d   = '0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (load_a) begin
                        a_d     = data_in;
                        state_d = S_HAVE_A;
                    end else if (load_b || go) begin
                        err_d = 1'b1;
                    end
                end
                S_HAVE_A: begin
                    if (load_a) begin
                        a_d = data_in;
                    end else if (load_b) begin
                        b_d     = data_in;
                        state_d = S_HAVE_B;
                    end else if (go) begin
                        err_d = 1'b1;
                    end
                end
                S_HAVE_B: begin
                    if (load_a) begin
                        a_d = data_in;
                    end else if (load_b) begin
                        b_d = data_in;
                    end else if (go) begin
                        sub_d   = op_sub;
                        state_d = S_EXEC;
                    end
                end
                S_EXEC: begin
                    // first EXEC cycle lets the adder settle, second captures
                    err_d = load_a | load_b | go;
                    if (!settle_q) begin
                        settle_d = 1'b1;
                    end else begin
                        res_d   = cap_res;
                        flg_d   = cap_flg;
                        done_d  = 1'b1;
                        state_d = S_DONE;
                    end
                end
                S_DONE: begin
                    if (load_a) begin
                        a_d     = data_in;
                        state_d = S_HAVE_A;
                    end else if (load_b) begin
                        a_d     = res_q;
                        b_d     = data_in;
                        state_d = S_HAVE_B;
                    end else if (go) begin
                        err_d = 1'b1;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            sub_q    <= 1'b0;
            res_q    <= '0;
            flg_q    <= '0;
            settle_q <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            sub_q    <= sub_d;
            res_q    <= res_d;
            flg_q    <= flg_d;
            settle_q <= settle_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    assign alu_a   = a_q;
    assign alu_b   = b_q;
    assign alu_sub = sub_q;
    assign result  = res_q;
    assign flags   = flg_q;
    assign busy    = (state_q == S_EXEC);
    assign done    = done_q;
    assign err     = err_q;

endmodule

// File: tb/tb_calc_op_sequencer.sv
// tb_calc_op_sequencer: directed and random checks of calc_op_sequencer
// against a protocol/arithmetic reference model with a behavioural adder.
module tb_calc_op_sequencer;

    logic       clk = 1'b0;
    logic       rst, load_a, load_b, op_sub, go, clear;
    logic [7:0] data_in;
    logic [7:0] alu_a, alu_b, alu_s, result;
    logic       alu_sub, alu_cout, alu_neg, alu_ovr, alu_zero;
    logic [3:0] flags;
    logic       busy, done, err;

    int ncmp = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    calc_op_sequencer #(.WIDTH(8)) dut (
        .clk(clk), .rst(rst), .data_in(data_in),
        .load_a(load_a), .load_b(load_b), .op_sub(op_sub),
        .go(go), .clear(clear),
        .alu_a(alu_a), .alu_b(alu_b), .alu_sub(alu_sub),
        .alu_s(alu_s), .alu_cout(alu_cout), .alu_neg(alu_neg),
        .alu_ovr(alu_ovr), .alu_zero(alu_zero),
        .result(result), .flags(flags),
        .busy(busy), .done(done), .err(err)
    );

    // behavioural ripple adder/subtractor: A + (sub ? ~B : B) + sub
    logic [7:0] bb;
    logic [8:0] sum9;
    assign bb       = alu_sub ? ~alu_b : alu_b;
    assign sum9     = {1'b0, alu_a} + {1'b0, bb} + {8'd0, alu_sub};
    assign alu_s    = sum9[7:0];
    assign alu_cout = sum9[8];
    assign alu_neg  = sum9[7];
    assign alu_ovr  = (alu_a[7] == bb[7]) && (sum9[7] != alu_a[7]);
    assign alu_zero = (sum9[7:0] == 8'd0);

    // reference model: phase 0 idle,1 haveA,2 haveB,3/4 exec,5 done
    int         m_ph;
    logic [7:0] m_a, m_b, m_res;
    logic       m_sub, m_done, m_err;
    logic [3:0] m_flg;

    task automatic arith(input logic [7:0] a, input logic [7:0] b,
                         input logic sub, output logic [7:0] r,
                         output logic [3:0] f);
        int sa, sb, s, u;
        logic co, ov;
        sa = int'($signed(a));
        sb = int'($signed(b));
        s  = sub ? sa - sb : sa + sb;
        u  = sub ? int'(a) - int'(b) : int'(a) + int'(b);
        co = sub ? (a >= b) : (u > 255);
        ov = (s > 127) || (s < -128);
        r  = 8'(u);
`ifdef SATURATE_EN
        if (ov) begin
            r = (sa < 0) ? 8'h80 : 8'h7F;
            f = {co, r[7], 1'b1, 1'b0};
            return;
        end
`endif
        f = {co, r[7], ov, (r == 8'd0)};
    endtask

    task automatic model(input logic r, c, la, lb, g, op, input logic [7:0] d);
        m_done = 1'b0;
        m_err  = 1'b0;
        if (r || c) begin
            m_ph = 0; m_a = 0; m_b = 0; m_sub = 0; m_res = 0; m_flg = 0;
        end else begin
            case (m_ph)
                0: if (la) begin m_a = d; m_ph = 1; end
                   else if (lb || g) m_err = 1'b1;
                1: if (la) m_a = d;
                   else if (lb) begin m_b = d; m_ph = 2; end
                   else if (g) m_err = 1'b1;
                2: if (la) m_a = d;
                   else if (lb) m_b = d;
                   else if (g) begin m_sub = op; m_ph = 3; end
                3: begin m_err = la | lb | g; m_ph = 4; end
                4: begin
                    m_err = la | lb | g;
                    arith(m_a, m_b, m_sub, m_res, m_flg);
                    m_done = 1'b1;
                    m_ph = 5;
                end
                default: if (la) begin m_a = d; m_ph = 1; end
                   else if (lb) begin m_a = m_res; m_b = d; m_ph = 2; end
                   else if (g) m_err = 1'b1;
            endcase
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic r, c, la, lb, g, op,
                        input logic [7:0] d);
        @(negedge clk);
        rst = r; clear = c; load_a = la; load_b = lb; go = g;
        op_sub = op; data_in = d;
        @(posedge clk);
        model(r, c, la, lb, g, op, d);
        #1;
        rst = 0; clear = 0; load_a = 0; load_b = 0; go = 0;
        chk("result", 32'(result), 32'(m_res));
        chk("flags", 32'(flags), 32'(m_flg));
        chk("done", 32'(done), 32'(m_done));
        chk("err", 32'(err), 32'(m_err));
        chk("busy", 32'(busy), 32'(m_ph == 3 || m_ph == 4));
        chk("alu_a", 32'(alu_a), 32'(m_a));
        chk("alu_b", 32'(alu_b), 32'(m_b));
        chk("alu_sub", 32'(alu_sub), 32'(m_sub));
    endtask

    task automatic run(input logic [7:0] a, input logic [7:0] b,
                       input logic sub);
        step(0, 0, 1, 0, 0, 0, a);
        step(0, 0, 0, 1, 0, 0, b);
        step(0, 0, 0, 0, 1, sub, 8'h00);
        step(0, 0, 0, 0, 0, 0, 8'h00);
        step(0, 0, 0, 0, 0, 0, 8'h00);
    endtask

    initial begin
        rst = 1; clear = 0; load_a = 0; load_b = 0; go = 0;
        op_sub = 0; data_in = 0;
        m_ph = 0; m_a = 0; m_b = 0; m_sub = 0; m_res = 0; m_flg = 0;
        m_done = 0; m_err = 0;
        step(1, 0, 0, 0, 0, 0, 8'h00);
        step(0, 0, 0, 0, 0, 0, 8'h00);
        chk("reset_result", 32'(result), 32'h0);
        // errors in IDLE
        step(0, 0, 0, 0, 1, 0, 8'h00);
        step(0, 0, 0, 1, 0, 0, 8'h11);
        // directed arithmetic
        run(8'h05, 8'h03, 0);
        chk("t1_result", 32'(result), 32'h08);
        chk("t1_flags", 32'(flags), 32'h0);
        run(8'h05, 8'h07, 1);
        chk("t2_result", 32'(result), 32'hFE);
        chk("t2_flags", 32'(flags), 32'b0100);
        run(8'h7F, 8'h01, 0);
`ifdef SATURATE_EN
        chk("t3_result", 32'(result), 32'h7F);
`else
        chk("t3_result", 32'(result), 32'h80);
        chk("t3_flags", 32'(flags), 32'b0110);
`endif
        run(8'h03, 8'h03, 1);
        chk("t4_result", 32'(result), 32'h00);
        chk("t4_flags", 32'(flags), 32'b1001);
        // chain: A <= previous result
        step(0, 0, 0, 1, 0, 0, 8'h02);
        step(0, 0, 0, 0, 1, 1, 8'h00);
        step(0, 0, 1, 0, 0, 0, 8'h44);
        step(0, 0, 0, 1, 1, 0, 8'h55);
        chk("t4_chain", 32'(result), 32'hFE);
        // load_a with go in HAVE_B: A updated, no EXEC
        run(8'h10, 8'h20, 0);
        step(0, 0, 0, 1, 0, 0, 8'h01);
        step(0, 0, 1, 0, 1, 0, 8'h09);
        chk("t5_nobusy", 32'(busy), 32'h0);
        // reset during EXEC aborts
        step(0, 0, 0, 0, 1, 0, 8'h00);
        step(1, 0, 0, 0, 0, 0, 8'h00);
        step(0, 0, 0, 0, 0, 0, 8'h00);
        chk("t6_done", 32'(done), 32'h0);
        // clear during EXEC aborts too
        run(8'h22, 8'h33, 0);
        step(0, 0, 0, 1, 0, 0, 8'h01);
        step(0, 0, 0, 0, 1, 1, 8'h00);
        step(0, 1, 0, 0, 0, 0, 8'h00);
        // randomized strobes against the model
        for (int i = 0; i < 600; i++) begin
            logic r, c, la, lb, g;
            r  = ($urandom_range(0, 99) < 2);
            c  = ($urandom_range(0, 99) < 3);
            la = ($urandom_range(0, 99) < 20);
            lb = ($urandom_range(0, 99) < 30);
            g  = ($urandom_range(0, 99) < 35);
            step(r, c, la, lb, g, 1'($urandom), 8'($urandom));
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule
